cordic_rotate: RTL
==================

// Module: cordic_rotate
// PURPOSE
//  Iterative CORDIC in rotation mode. It is the inverse companion of the vectoring-mode angle
//  unit: it takes an angle in radians and returns cos/sin. Sits behind the APB slave beside
//  the vectoring unit and uses the same START / PREADY / OP_DONE handshake.
//  Runs one micro-rotation per clock. Gain is pre-compensated, so the outputs are unit-scaled.
// PARAMETERS
//  ITER    20        number of micro-rotations (i = 0..ITER-1); atan LUT depth
//  FRAC    19        fractional bits of every fixed-point port and register
//  K_INIT  31'h4DBA7 initial x = 0.607253 (1/CORDIC gain) in Q12.19
// PORTS
//  iCLK      in   1   clock, rising edge
//  nRST      in   1   synchronous, active-low reset
//  START     in   1   request; sampled only in IDLE
//  iangle    in   27  signed Q8.19 angle in radians, valid range [-PI, +PI]
//  PREADY    out  1   high in IDLE and DONE; low in BUSY
//  OP_DONE   out  1   one-cycle pulse: ocos/osin are valid
//  ocos      out  31  signed Q12.19 cos(iangle)
//  osin      out  31  signed Q12.19 sin(iangle)
// BEHAVIOUR
//  Reset (nRST low at a rising edge):
//   - state=IDLE, i=0, x/y/z=0, flip=0
//   - OP_DONE=0, PREADY=1, ocos=osin=0
//   - Reset wins over any in-flight operation; that result is discarded.
//  FSM:
//   - IDLE -> BUSY on START. Otherwise stay.
//   - BUSY -> DONE at the edge that completes i==ITER-1.
//   - DONE -> IDLE unconditionally (1 cycle). START is ignored in BUSY and DONE.
//  Capture (IDLE&START edge):
//   - Clamp iangle to [-PI, +PI]. PI = Q8.19 0x1921FB.
//   - Fold into [-PI/2, +PI/2]:
//     - angle > +PI/2: z0 = angle - PI, flip = 1
//     - angle < -PI/2: z0 = angle + PI, flip = 1
//     - otherwise: z0 = angle, flip = 0
//     - Exactly +/-PI/2 is not folded.
//   - x0 = K_INIT, y0 = 0, i = 0.
//  Iteration (each BUSY edge); d = sign bit of z:
//   - d=0: x' = x - (y>>>i), y' = y + (x>>>i), z' = z - atan[i]
//   - d=1: x' = x + (y>>>i), y' = y - (x>>>i), z' = z + atan[i]
//   - >>> is an arithmetic shift. x, y are 31-bit; z is 27-bit. No saturation is needed: |x|,|y| < 2.
//   - atan[i] = round(atan(2^-i) * 2^19). i=0 is 19'h6487F, i=19 is 1.
//  Completion (edge leaving BUSY):
//   - ocos = flip ? -x' : x'; osin = flip ? -y' : y'.
//   - OP_DONE <= 1 for exactly the DONE cycle.
//   - ocos/osin hold until the next accepted START, which clears them to 0.
//  Latency and throughput:
//   - START accepted at edge k; OP_DONE is high in the cycle after edge k+ITER.
//   - With START held high, back-to-back period is ITER+2 cycles.
//  Accuracy: |error| <= 8 LSB (2^-16) on both outputs over the full range.
// TESTING
//  T1 iangle=0 -> ocos=524288+/-8, osin=0+/-8; OP_DONE exactly 20 edges after START accepted.
//  T2 iangle=411775 (PI/4) -> ocos=osin=370728+/-8; PREADY low for all 20 BUSY cycles.
//  T3 iangle=+PI (0x1921FB), then -PI -> ocos=-524288+/-8, osin=0+/-8 (fold path, flip=1).
//  T4 iangle=-823550 (-PI/2) -> ocos=0+/-8, osin=-524288+/-8; iangle=+2*PI clamps to +PI result.
//  T5 nRST low at i=10 -> next edge: IDLE, PREADY=1, OP_DONE=0, ocos=osin=0; new START runs clean.
//  T6 START held high, 3 angles -> OP_DONE pulses 22 cycles apart; START ignored in BUSY/DONE.

Source files
------------

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: angle in radians (Q8.19) to unit-scaled cos/sin (Q12.19).
// One micro-rotation per clock; quadrant folding extends convergence to the full [-PI, +PI] range.
module cordic_rotate #(
  parameter int                 ITER   = 20,
  parameter int                 FRAC   = 19,
  parameter logic signed [30:0] K_INIT = 31'h4DBA7
) (
  input  logic               iCLK,
  input  logic               nRST,
  input  logic               START,
  input  logic signed [26:0] iangle,
  output logic               PREADY,
  output logic               OP_DONE,
  output logic signed [30:0] ocos,
  output logic signed [30:0] osin
);

  localparam int W_ANG = 8 + FRAC;
  localparam int W_XY  = 12 + FRAC;
  localparam int IW    = $clog2(ITER);

  localparam logic signed [W_ANG-1:0] PI          = 27'sh1921FB;
  localparam logic signed [W_ANG-1:0] NEG_PI      = -PI;
  localparam logic signed [W_ANG-1:0] HALF_PI     = 27'sh0C90FE;
  localparam logic signed [W_ANG-1:0] NEG_HALF_PI = -HALF_PI;
  localparam logic [IW-1:0]           LAST_ITER   = IW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IW-1:0]           r_i;
  logic signed [W_XY-1:0]  r_x;
  logic signed [W_XY-1:0]  r_y;
  logic signed [W_ANG-1:0] r_z;
  logic                    r_flip;

  logic signed [W_ANG-1:0] w_clamped;
  logic signed [W_ANG-1:0] w_z0;
  logic                    w_flip;
  logic signed [W_XY-1:0]  w_xShift;
  logic signed [W_XY-1:0]  w_yShift;
  logic signed [W_ANG-1:0] w_atan;
  logic signed [W_XY-1:0]  w_xNext;
  logic signed [W_XY-1:0]  w_yNext;
  logic signed [W_ANG-1:0] w_zNext;

  // atan(2^-i) rounded to Q8.19
  function automatic logic signed [W_ANG-1:0] atanLut(input logic [IW-1:0] idx);
    case (int'(idx))
      0:  atanLut = 27'sd411775;
      1:  atanLut = 27'sd243085;
      2:  atanLut = 27'sd128439;
      3:  atanLut = 27'sd65198;
      4:  atanLut = 27'sd32725;
      5:  atanLut = 27'sd16379;
      6:  atanLut = 27'sd8191;
      7:  atanLut = 27'sd4096;
      8:  atanLut = 27'sd2048;
      9:  atanLut = 27'sd1024;
      10: atanLut = 27'sd512;
      11: atanLut = 27'sd256;
      12: atanLut = 27'sd128;
      13: atanLut = 27'sd64;
      14: atanLut = 27'sd32;
      15: atanLut = 27'sd16;
      16: atanLut = 27'sd8;
      17: atanLut = 27'sd4;
      18: atanLut = 27'sd2;
      19: atanLut = 27'sd1;
      default: atanLut = '0;
    endcase
  endfunction

  always_comb begin
    w_next  = r_state;
    PREADY  = 1'b1;
    OP_DONE = 1'b0;
    case (r_state)
      IDLE: if (START) w_next = BUSY;
      BUSY: begin
        PREADY = 1'b0;
        if (r_i == LAST_ITER) w_next = DONE;
      end
      DONE: begin
        OP_DONE = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outer quadrants are rotated by PI and the result negated, since CORDIC only converges to ~1.74 rad
  always_comb begin
    w_clamped = iangle;
    if (iangle > PI)          w_clamped = PI;
    else if (iangle < NEG_PI) w_clamped = NEG_PI;
    w_z0   = w_clamped;
    w_flip = 1'b0;
    if (w_clamped > HALF_PI) begin
      w_z0   = w_clamped - PI;
      w_flip = 1'b1;
    end else if (w_clamped < NEG_HALF_PI) begin
      w_z0   = w_clamped + PI;
      w_flip = 1'b1;
    end
  end

  always_comb begin
    w_xShift = r_x >>> r_i;
    w_yShift = r_y >>> r_i;
    w_atan   = atanLut(r_i);
    if (!r_z[W_ANG-1]) begin
      w_xNext = r_x - w_yShift;
      w_yNext = r_y + w_xShift;
      w_zNext = r_z - w_atan;
    end else begin
      w_xNext = r_x + w_yShift;
      w_yNext = r_y - w_xShift;
      w_zNext = r_z + w_atan;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_flip  <= 1'b0;
      ocos    <= '0;
      osin    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (START) begin
          r_x    <= K_INIT;
          r_y    <= '0;
          r_z    <= w_z0;
          r_flip <= w_flip;
          r_i    <= '0;
          ocos   <= '0;
          osin   <= '0;
        end
        BUSY: begin
          r_x <= w_xNext;
          r_y <= w_yNext;
          r_z <= w_zNext;
          r_i <= r_i + 1'b1;
          if (r_i == LAST_ITER) begin
            ocos <= r_flip ? -w_xNext : w_xNext;
            osin <= r_flip ? -w_yNext : w_yNext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
